// File: rtl/muldiv_seq.sv
// Sequential 32-iteration multiplier/divider with MIPS-style HI/LO result pair.
// Signed operations run on magnitudes; the sign is restored in the FIX cycle.
module muldiv_seq #(
  parameter int unsigned DP_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DP_WIDTH-1:0] a,
  input  logic [DP_WIDTH-1:0] b,
  input  logic                flush,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [DP_WIDTH-1:0] hi,
  output logic [DP_WIDTH-1:0] lo
);

  localparam int unsigned W     = DP_WIDTH;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_mag_b;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_mq;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_res;
  logic             r_sign_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;

  // Operand magnitudes at acceptance (op[0] selects signed interpretation)
  logic [W-1:0] w_abs_a;
  logic [W-1:0] w_abs_b;
  assign w_abs_a = (op[0] && a[W-1]) ? W'(~a + 1'b1) : a;
  assign w_abs_b = (op[0] && b[W-1]) ? W'(~b + 1'b1) : b;

  // Multiply step: conditional add, then shift {carry, acc, mq} right by one
  logic [W:0] w_add;
  assign w_add = {1'b0, r_acc} + {1'b0, (r_mq[0] ? r_mag_b : W'(0))};

  // Divide step: shift next dividend bit into remainder, trial-subtract divisor.
  // Remainder stays below the divisor, so W+1 signed bits hold the difference.
  logic [W:0] w_shl;
  logic [W:0] w_sub;
  logic       w_qbit;
  assign w_shl  = {r_acc, r_mq[W-1]};
  assign w_sub  = w_shl - {1'b0, r_mag_b};
  assign w_qbit = ~w_sub[W];

  // Sign correction applied in FIX
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_quo_fix;
  logic [W-1:0]   w_rem_fix;
  logic           w_dbz;
  assign w_prod     = {r_acc, r_mq};
  assign w_prod_fix = r_sign_res ? (2*W)'(~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_sign_res ? W'(~r_mq + 1'b1) : r_mq;
  assign w_rem_fix  = r_sign_rem ? W'(~r_acc + 1'b1) : r_acc;
  assign w_dbz      = (r_b == W'(0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= 2'b00;
      r_a        <= W'(0);
      r_b        <= W'(0);
      r_mag_b    <= W'(0);
      r_acc      <= W'(0);
      r_mq       <= W'(0);
      r_cnt      <= CNT_W'(0);
      r_sign_res <= 1'b0;
      r_sign_rem <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= W'(0);
      r_lo       <= W'(0);
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_op       <= op;
            r_a        <= a;
            r_b        <= b;
            r_mag_b    <= w_abs_b;
            r_acc      <= W'(0);
            r_mq       <= w_abs_a;
            r_cnt      <= CNT_W'(0);
            r_sign_res <= op[0] & (a[W-1] ^ b[W-1]);
            r_sign_rem <= op[0] & a[W-1];
            r_busy     <= 1'b1;
            r_state    <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            if (r_op[1]) begin
              r_acc <= w_qbit ? w_sub[W-1:0] : w_shl[W-1:0];
              r_mq  <= {r_mq[W-2:0], w_qbit};
            end else begin
              r_acc <= w_add[W:1];
              r_mq  <= {w_add[0], r_mq[W-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(W - 1)) begin
              r_state <= FIX;
            end
          end
        end
        FIX: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
          if (!flush) begin
            r_done <= 1'b1;
            if (!r_op[1]) begin
              {r_hi, r_lo} <= w_prod_fix;
            end else if (w_dbz) begin
              r_hi  <= r_a;
              r_lo  <= {W{1'b1}};
              r_dbz <= 1'b1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: results, latency, ignored start, flush and reset abort.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int lat;
  int ndone;

  muldiv_seq #(.DP_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for exactly one edge (edge k)
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  // Edges until done is seen (0 on timeout)
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int edges, output int n);
    n = 0;
    for (int i = 0; i < edges; i++) begin
      tick();
      if (done) n++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edbz);
    int n;
    start_op(o, x, y);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_dbz_low"}, {63'd0, div_by_zero}, 64'd0);
    chk({tag, "_hold"}, {hi, lo}, {ehi, elo});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    flush = 1'b0;
    tick();
    tick();
    chk("reset_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    run_check("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_check("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_check("div_neg7", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_check("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_check("divu_7_2", 2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    run_check("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_check("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_check("mult_big", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);

    // Second start at k+5 is ignored
    start_op(2'b00, 32'd3, 32'd4);
    repeat (4) tick();
    start_op(2'b00, 32'd100, 32'd100);
    wait_done(lat);
    chk("ign_latency", 64'(lat), 64'd28);
    chk("ign_hilo", {hi, lo}, 64'd12);
    count_done(40, ndone);
    chk("ign_extra_done", 64'(ndone), 64'd0);

    // Flush at k+10 aborts with no result write
    start_op(2'b10, 32'd100, 32'd7);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    count_done(40, ndone);
    chk("flush_no_done", 64'(ndone), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'd12);

    // start with flush in IDLE stays idle
    flush = 1'b1;
    start_op(2'b00, 32'd9, 32'd9);
    flush = 1'b0;
    chk("sf_busy", 64'(busy), 64'd0);
    count_done(40, ndone);
    chk("sf_no_done", 64'(ndone), 64'd0);

    // Back-to-back: start in the done cycle
    start_op(2'b00, 32'd6, 32'd7);
    wait_done(lat);
    chk("b2b_lat1", 64'(lat), 64'd33);
    chk("b2b_hilo1", {hi, lo}, 64'd42);
    start_op(2'b10, 32'd50, 32'd7);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("b2b_lat2", 64'(lat), 64'd33);
    chk("b2b_hilo2", {hi, lo}, {32'd1, 32'd7});
    tick();

    // Reset at k+20 aborts the operation
    start_op(2'b01, 32'd9, 32'd9);
    repeat (19) tick();
    rst_n = 1'b0;
    start = 1'b1;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    chk("rst_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    count_done(40, ndone);
    chk("rst_no_done", 64'(ndone), 64'd0);
    run_check("post_rst", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
